// File: rtl/lfsr_pkg.sv
// Shared constants, FSM state encoding and the LFSR next-state function
// for the LFSR sequencer.
package lfsr_pkg;

  localparam int LFSR_W = 5;
  localparam int CNT_W  = 5;

  // Loaded in place of an all-zero seed, which would lock the LFSR up.
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB     = 5'b00001;
  localparam logic [LFSR_W-1:0] SEED_INIT_DEFAULT = 5'b00001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    DELIVER = 2'd2
  } state_e;

  // One LFSR advance.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n[0] = s[1] ^ s[0];
    n[1] = s[2] ^ s[0];
    n[2] = s[3];
    n[3] = s[4] ^ s[0];
    n[4] = s[0];
    return n;
  endfunction

endpackage

// File: rtl/lfsr5_step.sv
// 5-bit LFSR register with load / advance / hold control.
// Load has priority over advance; with neither asserted the value holds.
module lfsr5_step
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED_INIT = SEED_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  // LFSR state: reset to SEED_INIT, load (zero seed substituted) or advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED_INIT;
    end else if (load) begin
      q <= (seed == '0) ? ZERO_SEED_SUB : seed;
    end else if (advance) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// LFSR sequencer: round-robin arbitration between two requesters, STEPS
// LFSR advances per service, then the value is presented until accepted.
//
// Handshake: a requester raises req[i] and holds it. gnt[i] marks the
// requester being served. While rnd_valid=1 the granted requester may take
// rnd_data; it signals acceptance by dropping req[i], which ends the
// service on the next edge. Dropping req[i] before rnd_valid abandons the
// service: stepping still runs to completion, then no data is offered.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int                STEPS     = 5,
  parameter logic [LFSR_W-1:0] SEED_INIT = SEED_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_wr,
  input  logic [LFSR_W-1:0] seed,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  output logic              rnd_valid,
  output logic [LFSR_W-1:0] rnd_data,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam logic [CNT_W-1:0] STEPS_CNT = CNT_W'(STEPS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             ptr_q, ptr_d;    // requester holding priority
  logic             drop_q, drop_d;  // granted req seen low during STEP
  logic             lfsr_load;
  logic             lfsr_adv;
  logic             winner;
  logic             held;
  logic [LFSR_W-1:0] lfsr_q;

  lfsr5_step #(
    .SEED_INIT (SEED_INIT)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (seed),
    .q       (lfsr_q)
  );

  // Round-robin pick: the priority holder wins if requesting, else the other.
  always_comb begin
    winner = 1'b0;
    if (ptr_q) winner = req[1] ? 1'b1 : 1'b0;
    else       winner = req[0] ? 1'b0 : 1'b1;
  end

  // Granted requester still holding its request.
  assign held = |(req & gnt_q);

  // Next-state and control decode for the IDLE/STEP/DELIVER sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    drop_d    = drop_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (seed_wr) begin
          lfsr_load = 1'b1;
        end else if (req != 2'b00) begin
          gnt_d   = winner ? 2'b10 : 2'b01;
          cnt_d   = STEPS_CNT;
          drop_d  = 1'b0;
          state_d = STEP;
        end
      end
      STEP: begin
        if (!held) drop_d = 1'b1;
        if (cnt_q != '0) begin
          lfsr_adv = 1'b1;
          cnt_d    = cnt_q - 5'd1;
        end else if (drop_q || !held) begin
          // Abandoned service: no data phase, priority still passes on.
          state_d = IDLE;
          gnt_d   = 2'b00;
          ptr_d   = ~gnt_q[1];
        end else begin
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        if (!held) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          ptr_d   = ~gnt_q[1];
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      ptr_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = (state_q == DELIVER);
  assign busy      = (state_q != IDLE);
  assign rnd_data  = lfsr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: one instance with STEPS=1 driven from a vector
// table and an alternation sequence, one with STEPS=5 for reset-abort,
// abandoned-service and latency sequences.
module tb_lfsr_seq_ctrl;

  localparam int S1 = 1;
  localparam int S5 = 5;

  typedef struct {
    logic       seed_wr;
    logic [4:0] seed;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       valid;
    logic [4:0] data;
    logic       busy;
  } vec_t;

  logic clk;
  logic rst1_n, rst5_n;
  logic seed_wr1, seed_wr5;
  logic [4:0] seed1, seed5;
  logic [1:0] req1, req5;
  logic [1:0] gnt1, gnt5;
  logic rnd_valid1, rnd_valid5;
  logic [4:0] rnd_data1, rnd_data5;
  logic busy1, busy5;
  logic [1:0] st1, st5;

  int n_checks = 0;
  int n_fail   = 0;

  // {gnt, valid, data, busy}
  logic [8:0] exp_q[$];

  lfsr_seq_ctrl #(.STEPS(S1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .seed_wr(seed_wr1), .seed(seed1), .req(req1),
    .gnt(gnt1), .rnd_valid(rnd_valid1), .rnd_data(rnd_data1), .busy(busy1),
    .state_dbg(st1)
  );

  lfsr_seq_ctrl #(.STEPS(S5)) dut5 (
    .clk(clk), .rst_n(rst5_n), .seed_wr(seed_wr5), .seed(seed5), .req(req5),
    .gnt(gnt5), .rnd_valid(rnd_valid5), .rnd_data(rnd_data5), .busy(busy5),
    .state_dbg(st5)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] model_next(input logic [4:0] s);
    return {s[0], s[4] ^ s[0], s[3], s[2] ^ s[0], s[1] ^ s[0]};
  endfunction

  function automatic vec_t mk(input logic sw, input logic [4:0] sd, input logic [1:0] rq,
                              input logic [1:0] g, input logic v, input logic [4:0] d,
                              input logic b);
    vec_t r;
    r.seed_wr = sw; r.seed = sd; r.req = rq;
    r.gnt = g; r.valid = v; r.data = d; r.busy = b;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t vecs[17];
    logic [8:0] e;
    logic [4:0] m;
    logic p;
    int delivers, grants, n, lat;
    logic prev_g, prev_v, saw_valid;

    // STEPS=1 table: inputs applied for one edge, outputs sampled after it.
    vecs[0]  = mk(1'b0, 5'b00000, 2'b00, 2'b00, 1'b0, 5'b00001, 1'b0);
    vecs[1]  = mk(1'b0, 5'b00000, 2'b01, 2'b01, 1'b0, 5'b00001, 1'b1);
    vecs[2]  = mk(1'b0, 5'b00000, 2'b01, 2'b01, 1'b0, 5'b11011, 1'b1);
    vecs[3]  = mk(1'b0, 5'b00000, 2'b01, 2'b01, 1'b1, 5'b11011, 1'b1);
    vecs[4]  = mk(1'b0, 5'b00000, 2'b01, 2'b01, 1'b1, 5'b11011, 1'b1);
    vecs[5]  = mk(1'b0, 5'b00000, 2'b00, 2'b00, 1'b0, 5'b11011, 1'b0);
    vecs[6]  = mk(1'b1, 5'b10110, 2'b10, 2'b00, 1'b0, 5'b10110, 1'b0);
    vecs[7]  = mk(1'b0, 5'b00000, 2'b10, 2'b10, 1'b0, 5'b10110, 1'b1);
    vecs[8]  = mk(1'b0, 5'b00000, 2'b10, 2'b10, 1'b0, 5'b01011, 1'b1);
    vecs[9]  = mk(1'b0, 5'b00000, 2'b10, 2'b10, 1'b1, 5'b01011, 1'b1);
    vecs[10] = mk(1'b0, 5'b00000, 2'b00, 2'b00, 1'b0, 5'b01011, 1'b0);
    vecs[11] = mk(1'b1, 5'b00000, 2'b00, 2'b00, 1'b0, 5'b00001, 1'b0);
    vecs[12] = mk(1'b1, 5'b11111, 2'b00, 2'b00, 1'b0, 5'b11111, 1'b0);
    vecs[13] = mk(1'b0, 5'b00000, 2'b01, 2'b01, 1'b0, 5'b11111, 1'b1);
    vecs[14] = mk(1'b1, 5'b00100, 2'b01, 2'b01, 1'b0, 5'b10100, 1'b1);
    vecs[15] = mk(1'b1, 5'b00100, 2'b01, 2'b01, 1'b1, 5'b10100, 1'b1);
    vecs[16] = mk(1'b0, 5'b00000, 2'b00, 2'b00, 1'b0, 5'b10100, 1'b0);

    // Reset phase.
    rst1_n = 1'b0; rst5_n = 1'b0;
    seed_wr1 = 1'b0; seed_wr5 = 1'b0;
    seed1 = '0; seed5 = '0;
    req1 = 2'b00; req5 = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt1", gnt1, 2'b00);
    check("rst_valid1", rnd_valid1, 1'b0);
    check("rst_busy5", busy5, 1'b0);
    @(negedge clk);
    rst1_n = 1'b1; rst5_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_data1", rnd_data1, 5'b00001);
    check("post_rst_gnt1", gnt1, 2'b00);
    check("post_rst_busy1", busy1, 1'b0);
    check("post_rst_data5", rnd_data5, 5'b00001);
    check("post_rst_busy5", busy5, 1'b0);

    // Table-driven vectors on the STEPS=1 instance.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      seed_wr1 = vecs[i].seed_wr;
      seed1    = vecs[i].seed;
      req1     = vecs[i].req;
      exp_q.push_back({vecs[i].gnt, vecs[i].valid, vecs[i].data, vecs[i].busy});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("vec%0d_gnt", i), gnt1, e[8:7]);
      check($sformatf("vec%0d_valid", i), rnd_valid1, e[6]);
      check($sformatf("vec%0d_data", i), rnd_data1, e[5:1]);
      check($sformatf("vec%0d_busy", i), busy1, e[0]);
    end
    @(negedge clk);
    seed_wr1 = 1'b0;
    req1 = 2'b00;

    // Alternation with both requesters held; each takes its data by a
    // one-cycle drop of its req bit.
    rst1_n = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1;
    m = 5'b00001;
    p = 1'b0;
    for (int s = 0; s < 3; s++) begin
      m = model_next(m);
      exp_q.push_back({(p ? 2'b10 : 2'b01), 1'b1, m, 1'b1});
      p = ~p;
    end
    req1 = 2'b11;
    delivers = 0; grants = 0; prev_g = 1'b0; prev_v = 1'b0;
    for (int c = 0; c < 60 && delivers < 3; c++) begin
      @(posedge clk);
      #1;
      check("alt_onehot", $onehot0(gnt1), 1'b1);
      if (gnt1 != 2'b00 && !prev_g) grants++;
      if (rnd_valid1 && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("alt_extra_deliver", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("alt%0d_gnt", delivers), gnt1, e[8:7]);
          check($sformatf("alt%0d_data", delivers), rnd_data1, e[5:1]);
        end
        delivers++;
      end
      prev_g = (gnt1 != 2'b00);
      prev_v = rnd_valid1;
      if (delivers < 3) begin
        @(negedge clk);
        req1 = rnd_valid1 ? (2'b11 & ~gnt1) : 2'b11;
      end
    end
    check("alt_delivers", delivers, 3);
    check("alt_grants", grants, 3);
    check("alt_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    req1 = 2'b00;
    @(posedge clk);
    #1;
    check("alt_end_busy", busy1, 1'b0);

    // Reset asserted in the third STEP cycle of the STEPS=5 instance.
    @(negedge clk);
    req5 = 2'b01;
    @(posedge clk);
    #1;
    check("abort_gnt", gnt5, 2'b01);
    repeat (2) @(posedge clk);
    #2;
    rst5_n = 1'b0;
    #1;
    check("abort_gnt_async", gnt5, 2'b00);
    check("abort_busy_async", busy5, 1'b0);
    check("abort_valid_async", rnd_valid5, 1'b0);
    check("abort_data_async", rnd_data5, 5'b00001);
    check("abort_state_async", st5, 2'd0);
    req5 = 2'b00;
    @(negedge clk);
    rst5_n = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (rnd_valid5 || busy5) saw_valid = 1'b1;
    end
    check("abort_no_service", saw_valid, 1'b0);

    // Granted request dropped during STEP: stepping completes, no data phase.
    @(negedge clk);
    req5 = 2'b01;
    @(posedge clk);
    #1;
    check("drop_gnt", gnt5, 2'b01);
    @(negedge clk);
    req5 = 2'b00;
    n = 0;
    saw_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      n++;
      if (rnd_valid5) saw_valid = 1'b1;
      if (!busy5) break;
    end
    m = 5'b00001;
    for (int s = 0; s < S5; s++) m = model_next(m);
    check("drop_idle_cycles", n, S5 + 1);
    check("drop_no_valid", saw_valid, 1'b0);
    check("drop_data", rnd_data5, m);
    check("drop_gnt_idle", gnt5, 2'b00);

    // Next arbitration goes to the other requester; check latency and data.
    @(negedge clk);
    req5 = 2'b11;
    @(posedge clk);
    #1;
    check("next_gnt", gnt5, 2'b10);
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (rnd_valid5) break;
    end
    for (int s = 0; s < S5; s++) m = model_next(m);
    check("latency", lat, S5 + 1);
    check("next_valid", rnd_valid5, 1'b1);
    check("next_data", rnd_data5, m);
    check("next_gnt_hold", gnt5, 2'b10);
    @(negedge clk);
    req5 = 2'b00;
    @(posedge clk);
    #1;
    check("next_end_busy", busy5, 1'b0);
    check("next_end_gnt", gnt5, 2'b00);
    check("next_end_valid", rnd_valid5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
